// File: rtl/logic_sweep_pkg.sv
// Shared definitions for the logic sweep checker: FSM states, vector
// sizing and the golden reference function of the workshop lab block.
package logic_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One stimulus vector is {a,b,c,d}
    localparam int VEC_W = 4;
    localparam logic [VEC_W-1:0] LAST_VEC = 4'hF;

    // Reference behaviour of the lab block: out = ~(((a&b)|~c)&d)
    function automatic logic golden_out(input logic [VEC_W-1:0] vec);
        logic a;
        logic b;
        logic c;
        logic d;
        a = vec[3];
        b = vec[2];
        c = vec[1];
        d = vec[0];
        return ~(((a & b) | ~c) & d);
    endfunction

endpackage

// File: rtl/logic_sweep_settle_cnt.sv
// Settle-time down-counter for the logic sweep checker. Loaded with
// SETTLE_CYCLES when a new vector is put on the pins; expired is high
// during the last hold cycle so the controller moves on to sampling.
module logic_sweep_settle_cnt
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES);

    logic [7:0] count_q;

    // Reload on each new vector, then count down once per hold cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= LOAD_VAL;
        end else if (enable && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
        end
    end

    // A count of one means this is the final hold cycle of the vector
    assign expired = (count_q <= 8'd1);

endmodule

// File: rtl/logic_sweep_checker.sv
// Self-checking stimulus engine for four-input lab logic blocks.
// Sweeps {a,b,c,d} through 0..15, samples dut_out after a settle time and
// scores it against golden_out(). Optional first-failure capture is built
// only when LOGIC_SWEEP_FIRST_FAIL_EN is defined; otherwise those ports
// read as zero.
module logic_sweep_checker
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_fail_vec,
    output logic             first_fail_valid
);

    // With no settle time each vector is sampled in the cycle it is applied
    localparam state_t HOLD_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : APPLY;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic [VEC_W-1:0]  vec_q;
    logic [ERR_W-1:0]  err_q;
    logic              mismatch_seen_q;
    logic              pass_q;

    logic              load_cnt;
    logic              count_en;
    logic              sample_en;
    logic              clear_res;
    logic              expired;
    logic              mismatch;
    logic              last_vec;

    logic_sweep_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (load_cnt),
        .enable  (count_en),
        .expired (expired)
    );

    assign last_vec = (vec_q == LAST_VEC);
    assign mismatch = sample_en && (dut_out != golden_out(vec_q));

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        state_d   = state_q;
        load_cnt  = 1'b0;
        count_en  = 1'b0;
        sample_en = 1'b0;
        clear_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = HOLD_STATE;
                    load_cnt  = 1'b1;
                    clear_res = 1'b1;
                end
            end
            APPLY: begin
                count_en = 1'b1;
                if (expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_en = 1'b1;
                if (last_vec) begin
                    state_d = DONE;
                end else begin
                    state_d  = HOLD_STATE;
                    load_cnt = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stimulus vector: zeroed on start, stepped after each sample, and
    // left at the last vector once the sweep ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q <= '0;
        end else if (clear_res) begin
            vec_q <= '0;
        end else if (sample_en && !last_vec) begin
            vec_q <= vec_q + 4'd1;
        end
    end

    // Saturating mismatch counter for the current sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (clear_res) begin
            err_q <= '0;
        end else if (mismatch && (err_q != ERR_MAX)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    // Sticky mismatch flag, independent of the counter so a saturated
    // count can never look like a clean run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_seen_q <= 1'b0;
        end else if (clear_res) begin
            mismatch_seen_q <= 1'b0;
        end else if (mismatch) begin
            mismatch_seen_q <= 1'b1;
        end
    end

    // Verdict is published as the final sample is taken, visible from DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else if (clear_res) begin
            pass_q <= 1'b0;
        end else if (sample_en && last_vec) begin
            pass_q <= ~(mismatch_seen_q | mismatch);
        end
    end

`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
    logic [VEC_W-1:0] ff_vec_q;
    logic             ff_valid_q;

    // Latch the vector of the first mismatch in each sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else if (clear_res) begin
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else if (mismatch && !ff_valid_q) begin
            ff_vec_q   <= vec_q;
            ff_valid_q <= 1'b1;
        end
    end

    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
`else
    assign first_fail_vec   = 4'h0;
    assign first_fail_valid = 1'b0;
`endif

    assign a         = vec_q[3];
    assign b         = vec_q[2];
    assign c         = vec_q[1];
    assign d         = vec_q[0];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: three instances (settle 2, settle 0,
// narrow error counter) driven by behavioural lab blocks, scored against a
// sweep-level model plus hand-computed literals.
module tb_logic_sweep_checker;

    localparam int S0 = 2;
    localparam int W0 = 5;
    localparam int S1 = 0;
    localparam int W1 = 5;
    localparam int S2 = 2;
    localparam int W2 = 2;

    localparam int MODE_IDEAL  = 0;
    localparam int MODE_STUCK1 = 1;
    localparam int MODE_STUCK0 = 2;
    localparam int MODE_PIPE2  = 3;

`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
    localparam int FF_EN = 1;
`else
    localparam int FF_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic armed = 1'b0;

    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    int   mode0 = 0, mode1 = 0, mode2 = 0;

    logic [3:0] abcd0, abcd1, abcd2;
    logic       dut_out0, dut_out1, dut_out2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       pass0, pass1, pass2;
    logic [W0-1:0] err0;
    logic [W1-1:0] err1;
    logic [W2-1:0] err2;
    logic [3:0] ffv0, ffv1, ffv2;
    logic       ffval0, ffval1, ffval2;

    logic p1_0 = 1'b1, p2_0 = 1'b1;
    logic p1_1 = 1'b1, p2_1 = 1'b1;
    logic p1_2 = 1'b1, p2_2 = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt0 = 0;

    always #5 clk = ~clk;

    // Lab block truth table: output low exactly on vectors 1,5,9,13,15
    function automatic logic gold(input logic [3:0] v);
        case (v)
            4'd1, 4'd5, 4'd9, 4'd13, 4'd15: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic lab_resp(input int mode, input logic [3:0] v, input logic piped);
        case (mode)
            MODE_STUCK1: return 1'b1;
            MODE_STUCK0: return 1'b0;
            MODE_PIPE2:  return piped;
            default:     return gold(v);
        endcase
    endfunction

    // Two-register-stage flavours of the lab block
    always @(posedge clk) begin
        p1_0 <= gold(abcd0); p2_0 <= p1_0;
        p1_1 <= gold(abcd1); p2_1 <= p1_1;
        p1_2 <= gold(abcd2); p2_2 <= p1_2;
    end

    assign dut_out0 = lab_resp(mode0, abcd0, p2_0);
    assign dut_out1 = lab_resp(mode1, abcd1, p2_1);
    assign dut_out2 = lab_resp(mode2, abcd2, p2_2);

    logic_sweep_checker #(.SETTLE_CYCLES(S0), .ERR_W(W0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(abcd0[3]), .b(abcd0[2]), .c(abcd0[1]), .d(abcd0[0]),
        .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_vec(ffv0), .first_fail_valid(ffval0)
    );

    logic_sweep_checker #(.SETTLE_CYCLES(S1), .ERR_W(W1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(abcd1[3]), .b(abcd1[2]), .c(abcd1[1]), .d(abcd1[0]),
        .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffval1)
    );

    logic_sweep_checker #(.SETTLE_CYCLES(S2), .ERR_W(W2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a(abcd2[3]), .b(abcd2[2]), .c(abcd2[1]), .d(abcd2[0]),
        .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_vec(ffv2), .first_fail_valid(ffval2)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Whole-sweep outcome: what the lab block answers at each sample time
    task automatic compute_expect(input int s, input int w, input int mode, input int prev,
                                  output int e_err, output int e_pass,
                                  output int e_ffv, output int e_ffval);
        int cnt;
        int t;
        int src;
        int srcv;
        int maxv;
        logic r;
        cnt = 0;
        e_ffv = 0;
        e_ffval = 0;
        for (int v = 0; v < 16; v++) begin
            t = v * (s + 1) + s;
            src = t - 2;
            srcv = (src < 0) ? prev : src / (s + 1);
            case (mode)
                MODE_STUCK1: r = 1'b1;
                MODE_STUCK0: r = 1'b0;
                MODE_PIPE2:  r = gold(4'(srcv));
                default:     r = gold(4'(v));
            endcase
            if (r != gold(4'(v))) begin
                if (e_ffval == 0) begin
                    e_ffv = v;
                    e_ffval = 1;
                end
                cnt++;
            end
        end
        maxv = (1 << w) - 1;
        e_err = (cnt > maxv) ? maxv : cnt;
        e_pass = (cnt == 0) ? 1 : 0;
    endtask

    // Cycle position model for instance 0
    int mk = -1;
    int mlast = 0;
    int m_err = 0, m_pass = 0, m_ffv = 0, m_ffval = 0;
    int f_err = 0, f_pass = 0, f_ffv = 0, f_ffval = 0;
    localparam int DONE_K0 = 16 * (S0 + 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk = -1; mlast = 0;
            m_err = 0; m_pass = 0; m_ffv = 0; m_ffval = 0;
        end else if (mk < 0) begin
            if (start0) begin
                compute_expect(S0, W0, mode0, mlast, f_err, f_pass, f_ffv, f_ffval);
                mk = 0;
                m_err = 0; m_pass = 0; m_ffv = 0; m_ffval = 0;
            end
        end else begin
            mk++;
            if (mk == DONE_K0) begin
                m_err = f_err; m_pass = f_pass; m_ffv = f_ffv; m_ffval = f_ffval;
            end else if (mk > DONE_K0) begin
                mk = -1;
                mlast = 15;
            end
        end
    end

    // Per-cycle comparison of instance 0 against the model
    always @(negedge clk) begin
        int exp_vec;
        if (armed && !rst) begin
            if (mk < 0) exp_vec = mlast;
            else if (mk >= DONE_K0) exp_vec = 15;
            else exp_vec = mk / (S0 + 1);
            checkOutput("u0_busy", int'(busy0), (mk >= 0) ? 1 : 0);
            checkOutput("u0_done", int'(done0), (mk == DONE_K0) ? 1 : 0);
            checkOutput("u0_vec", int'(abcd0), exp_vec);
            if (mk < 0 || mk == DONE_K0) begin
                checkOutput("u0_err", int'(err0), m_err);
                checkOutput("u0_pass", int'(pass0), m_pass);
                checkOutput("u0_ffv", int'(ffv0), FF_EN ? m_ffv : 0);
                checkOutput("u0_ffval", int'(ffval0), FF_EN ? m_ffval : 0);
            end else begin
                checkOutput("u0_pass_busy", int'(pass0), 0);
            end
        end
        if (done0) done_cnt0++;
    end

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic set_mode(input int inst, input int m);
        case (inst)
            0: mode0 = m;
            1: mode1 = m;
            default: mode2 = m;
        endcase
    endtask

    function automatic logic get_busy(input int inst);
        case (inst)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int inst);
        case (inst)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    // Run one sweep; optionally re-pulse start at a given busy cycle
    task automatic applyStimulus(input int inst, input int mode, input int repulse_at,
                                 output int busy_cycles, output int done_at);
        int guard;
        set_mode(inst, mode);
        @(negedge clk);
        set_start(inst, 1'b1);
        @(negedge clk);
        set_start(inst, 1'b0);
        busy_cycles = 0;
        done_at = -1;
        guard = 0;
        while (get_busy(inst) && guard < 2000) begin
            busy_cycles++;
            if (get_done(inst)) done_at = busy_cycles;
            set_start(inst, (busy_cycles == repulse_at) ? 1'b1 : 1'b0);
            @(negedge clk);
            guard++;
        end
        set_start(inst, 1'b0);
        if (guard >= 2000) checkOutput("sweep_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int bc;
        int da;
        int dc_before;
        int guard;
        int e_err, e_pass, e_ffv, e_ffval;

        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_busy", int'(busy0), 0);
        checkOutput("rst_done", int'(done0), 0);
        checkOutput("rst_vec", int'(abcd0), 0);
        checkOutput("rst_pass", int'(pass0), 0);
        checkOutput("rst_err", int'(err0), 0);
        checkOutput("rst_ffval", int'(ffval0), 0);
        checkOutput("rst_err2", int'(err2), 0);
        rst = 1'b0;
        armed = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] ideal lab block, settle 2");
        applyStimulus(0, MODE_IDEAL, -1, bc, da);
        checkOutput("ideal_busy_cycles", bc, 49);
        checkOutput("ideal_done_cycle", da, 49);
        checkOutput("ideal_pass", int'(pass0), 1);
        checkOutput("ideal_err", int'(err0), 0);
        checkOutput("ideal_ffval", int'(ffval0), 0);
        checkOutput("ideal_vec_hold", int'(abcd0), 15);

        $display("[TB] stuck-at-1 lab block");
        applyStimulus(0, MODE_STUCK1, -1, bc, da);
        checkOutput("s1_err", int'(err0), 5);
        checkOutput("s1_pass", int'(pass0), 0);
        checkOutput("s1_ffv", int'(ffv0), FF_EN ? 1 : 0);
        checkOutput("s1_ffval", int'(ffval0), FF_EN);

        $display("[TB] two-stage lab block, settle 2");
        applyStimulus(0, MODE_PIPE2, -1, bc, da);
        checkOutput("pipe_s2_pass", int'(pass0), 1);
        checkOutput("pipe_s2_err", int'(err0), 0);

        $display("[TB] start re-pulsed mid-sweep");
        dc_before = done_cnt0;
        applyStimulus(0, MODE_IDEAL, 10, bc, da);
        checkOutput("repulse_busy_cycles", bc, 49);
        checkOutput("repulse_done_count", done_cnt0 - dc_before, 1);
        checkOutput("repulse_pass", int'(pass0), 1);

        $display("[TB] reset while vector 7 is driven");
        dc_before = done_cnt0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        guard = 0;
        while (abcd0 != 4'd7 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_vec7", int'(abcd0), 7);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", int'(busy0), 0);
        checkOutput("midrst_done", int'(done0), 0);
        checkOutput("midrst_vec", int'(abcd0), 0);
        checkOutput("midrst_pass", int'(pass0), 0);
        checkOutput("midrst_err", int'(err0), 0);
        checkOutput("midrst_ffval", int'(ffval0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_done", done_cnt0 - dc_before, 0);
        applyStimulus(0, MODE_IDEAL, -1, bc, da);
        checkOutput("after_rst_busy_cycles", bc, 49);
        checkOutput("after_rst_pass", int'(pass0), 1);

        $display("[TB] two-stage lab block, settle 0");
        applyStimulus(1, MODE_PIPE2, -1, bc, da);
        compute_expect(S1, W1, MODE_PIPE2, 0, e_err, e_pass, e_ffv, e_ffval);
        checkOutput("pipe_s0_busy_cycles", bc, 17);
        checkOutput("pipe_s0_pass", int'(pass1), 0);
        checkOutput("pipe_s0_err_nonzero", (err1 > 0) ? 1 : 0, 1);
        checkOutput("pipe_s0_err_model", int'(err1), e_err);
        checkOutput("pipe_s0_ffv", int'(ffv1), FF_EN ? e_ffv : 0);

        $display("[TB] stuck-at-0 lab block, 2-bit counter");
        applyStimulus(2, MODE_STUCK0, -1, bc, da);
        compute_expect(S2, W2, MODE_STUCK0, 0, e_err, e_pass, e_ffv, e_ffval);
        checkOutput("s0_err_sat", int'(err2), 3);
        checkOutput("s0_err_model", int'(err2), e_err);
        checkOutput("s0_pass", int'(pass2), 0);
        checkOutput("s0_ffv", int'(ffv2), 0);
        checkOutput("s0_ffval", int'(ffval2), FF_EN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
